// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-requester arbiter in front of a single-port synchronous RAM.
// Requester 0 is the core, requester 1 is the DMA/loader. Exactly one access
// is in flight at a time and walks IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   : ties in IDLE go to the requester that was not granted last
//               (first tie after reset goes to m0)
//   undefined : fixed priority, m0 always wins a tie
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  I_clk,
  input  logic                  I_reset,

  input  logic                  I_m0_exec,
  input  logic                  I_m0_write,
  input  logic [ADDR_WIDTH-1:0] I_m0_addr,
  input  logic [DATA_WIDTH-1:0] I_m0_data,
  output logic                  O_m0_ready,
  output logic [DATA_WIDTH-1:0] O_m0_data,
  output logic                  O_m0_data_ready,

  input  logic                  I_m1_exec,
  input  logic                  I_m1_write,
  input  logic [ADDR_WIDTH-1:0] I_m1_addr,
  input  logic [DATA_WIDTH-1:0] I_m1_data,
  output logic                  O_m1_ready,
  output logic [DATA_WIDTH-1:0] O_m1_data,
  output logic                  O_m1_data_ready,

  output logic                  O_ram_enable,
  output logic                  O_ram_write,
  output logic [ADDR_WIDTH-1:0] O_ram_addr,
  output logic [DATA_WIDTH-1:0] O_ram_data,
  input  logic [DATA_WIDTH-1:0] I_ram_data
);

  // Value loaded into the wait counter when the RAM strobe goes out.
  localparam logic [3:0] LAT_LOAD = 4'(RAM_LATENCY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                state;
  state_t                state_next;

  logic [3:0]            wait_cnt;
  logic                  last_wait;

  // Transaction context captured at accept time.
  logic                  grant;
  logic                  lat_write;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_data;

  logic                  win_m0;
  logic                  win_m1;
  logic                  accept;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Identity of the requester served by the most recent accept (1 = m1).
  logic                  last_grant;

  // On a tie, the requester that was not served last wins.
  always_comb begin
    win_m0 = I_m0_exec & (~I_m1_exec | last_grant);
    win_m1 = I_m1_exec & ~win_m0;
  end

  // Remember who was served so the next tie flips to the other requester.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= O_m1_ready;
    end
  end
`else
  // Fixed priority: the core always wins a tie.
  always_comb begin
    win_m0 = I_m0_exec;
    win_m1 = I_m1_exec & ~I_m0_exec;
  end
`endif

  // Handshake and RAM strobes are decoded straight from the state so that
  // a requester gets accepted in the same cycle it first asks while IDLE.
  always_comb begin
    O_m0_ready      = 1'b0;
    O_m1_ready      = 1'b0;
    O_m0_data_ready = 1'b0;
    O_m1_data_ready = 1'b0;
    O_ram_enable    = 1'b0;
    O_ram_write     = 1'b0;
    if (!I_reset) begin
      case (state)
        IDLE: begin
          O_m0_ready = win_m0;
          O_m1_ready = win_m1;
        end
        ISSUE: begin
          O_ram_enable = 1'b1;
          O_ram_write  = lat_write;
        end
        RESP: begin
          O_m0_data_ready = ~grant;
          O_m1_data_ready = grant;
        end
        default: begin
        end
      endcase
    end
  end

  assign accept     = O_m0_ready | O_m1_ready;
  assign last_wait  = (state == WAIT) && (wait_cnt <= 4'd1);
  assign O_ram_addr = lat_addr;
  assign O_ram_data = lat_data;

  // Next-state sequencing for a single outstanding transaction.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (last_wait) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset drops any transaction in flight.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the winner's request on accept; held until the next accept so
  // the RAM address/data lines stay stable between accesses.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      grant     <= 1'b0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_data  <= '0;
    end else if (accept) begin
      grant     <= O_m1_ready;
      lat_write <= O_m1_ready ? I_m1_write : I_m0_write;
      lat_addr  <= O_m1_ready ? I_m1_addr  : I_m0_addr;
      lat_data  <= O_m1_ready ? I_m1_data  : I_m0_data;
    end
  end

  // Count down the RAM read latency; loaded while the strobe is out.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      wait_cnt <= 4'd0;
    end else if (state == ISSUE) begin
      wait_cnt <= LAT_LOAD;
    end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Read data is sampled on the final wait cycle into the granted
  // requester's register only; writes leave both registers untouched.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      O_m0_data <= '0;
      O_m1_data <= '0;
    end else if (last_wait && !lat_write) begin
      if (grant) begin
        O_m1_data <= I_ram_data;
      end else begin
        O_m0_data <= I_ram_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. Two instances are built: one with
// RAM_LATENCY=1 (main target) and one with RAM_LATENCY=3. Each has its own
// small RAM model that returns 16'hDEAD on cycles where no read data is due.
// Honours MEM_ARB_ROUND_ROBIN_EN for the expected tie-break policy.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        m0_exec, m0_write, m1_exec, m1_write;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

  logic        a_m0_ready, a_m0_done, a_m1_ready, a_m1_done, a_ram_en, a_ram_wr;
  logic [15:0] a_m0_rdata, a_m1_rdata, a_ram_addr, a_ram_wdata, a_ram_rdata;
  logic        b_m0_ready, b_m0_done, b_m1_ready, b_m1_done, b_ram_en, b_ram_wr;
  logic [15:0] b_m0_rdata, b_m1_rdata, b_ram_addr, b_ram_wdata, b_ram_rdata;

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .RAM_LATENCY(LAT_A)) dut_a (
    .I_clk(clk), .I_reset(reset),
    .I_m0_exec(m0_exec), .I_m0_write(m0_write), .I_m0_addr(m0_addr), .I_m0_data(m0_wdata),
    .O_m0_ready(a_m0_ready), .O_m0_data(a_m0_rdata), .O_m0_data_ready(a_m0_done),
    .I_m1_exec(m1_exec), .I_m1_write(m1_write), .I_m1_addr(m1_addr), .I_m1_data(m1_wdata),
    .O_m1_ready(a_m1_ready), .O_m1_data(a_m1_rdata), .O_m1_data_ready(a_m1_done),
    .O_ram_enable(a_ram_en), .O_ram_write(a_ram_wr), .O_ram_addr(a_ram_addr),
    .O_ram_data(a_ram_wdata), .I_ram_data(a_ram_rdata)
  );

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .RAM_LATENCY(LAT_B)) dut_b (
    .I_clk(clk), .I_reset(reset),
    .I_m0_exec(m0_exec), .I_m0_write(m0_write), .I_m0_addr(m0_addr), .I_m0_data(m0_wdata),
    .O_m0_ready(b_m0_ready), .O_m0_data(b_m0_rdata), .O_m0_data_ready(b_m0_done),
    .I_m1_exec(m1_exec), .I_m1_write(m1_write), .I_m1_addr(m1_addr), .I_m1_data(m1_wdata),
    .O_m1_ready(b_m1_ready), .O_m1_data(b_m1_rdata), .O_m1_data_ready(b_m1_done),
    .O_ram_enable(b_ram_en), .O_ram_write(b_ram_wr), .O_ram_addr(b_ram_addr),
    .O_ram_data(b_ram_wdata), .I_ram_data(b_ram_rdata)
  );

  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  logic [15:0] pipe_a;
  logic [15:0] pipe_b [3];
  logic        preload;

  // RAM for the latency-1 instance: read data valid one cycle after the strobe.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= (i == 16) ? 16'hBEEF : 16'h0000;
    end else if (a_ram_en && a_ram_wr) begin
      mem_a[a_ram_addr[7:0]] <= a_ram_wdata;
    end
    pipe_a <= (a_ram_en && !a_ram_wr) ? mem_a[a_ram_addr[7:0]] : 16'hDEAD;
  end
  assign a_ram_rdata = pipe_a;

  // RAM for the latency-3 instance: read data valid three cycles after the strobe.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= (i == 64) ? 16'hCAFE : 16'h0000;
    end else if (b_ram_en && b_ram_wr) begin
      mem_b[b_ram_addr[7:0]] <= b_ram_wdata;
    end
    pipe_b[0] <= (b_ram_en && !b_ram_wr) ? mem_b[b_ram_addr[7:0]] : 16'hDEAD;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign b_ram_rdata = pipe_b[2];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset   = 1'b1;
    m0_exec = 1'b0;
    m1_exec = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        who;
    logic        write;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  // One complete transaction on the latency-1 instance; returns the cycle
  // offset of the completion pulse after acceptance and the pulse count.
  task automatic applyStimulus(input vec_t v, output int done_k, output int done_n);
    int   w;
    logic rdy;
    logic dn;
    @(negedge clk);
    if (v.who == 1'b0) begin
      m0_exec = 1'b1; m0_write = v.write; m0_addr = v.addr; m0_wdata = v.wdata;
    end else begin
      m1_exec = 1'b1; m1_write = v.write; m1_addr = v.addr; m1_wdata = v.wdata;
    end
    w = 0;
    #1;
    rdy = v.who ? a_m1_ready : a_m0_ready;
    while (!rdy && w < 20) begin
      @(negedge clk);
      #1;
      rdy = v.who ? a_m1_ready : a_m0_ready;
      w++;
    end
    checkOutput("tbl_accept", {31'd0, rdy}, 32'd1);
    @(negedge clk);
    m0_exec = 1'b0;
    m1_exec = 1'b0;
    done_k = -1;
    done_n = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      if (k == 1) begin
        checkOutput("tbl_ram_en_issue", {31'd0, a_ram_en}, 32'd1);
        checkOutput("tbl_ram_addr", {16'd0, a_ram_addr}, {16'd0, v.addr});
        checkOutput("tbl_ram_write", {31'd0, a_ram_wr}, {31'd0, v.write});
        if (v.write) checkOutput("tbl_ram_wdata", {16'd0, a_ram_wdata}, {16'd0, v.wdata});
      end
      if (k == 2) checkOutput("tbl_ram_en_wait", {31'd0, a_ram_en}, 32'd0);
      dn = v.who ? a_m1_done : a_m0_done;
      if (dn) begin
        done_n++;
        if (done_k < 0) done_k = k;
      end
    end
  endtask

  // Random traffic checked against a cycle-count model of a transaction:
  // accepted at cycle A, strobe at A+1, data sampled at A+1+L, pulse at A+2+L,
  // free again from A+3+L.
  task automatic runRandom(input int n_cycles);
    int          cyc, acc_cyc;
    bit          acc_valid, g, g_wr, last;
    bit          pend[2];
    bit          p_wr[2];
    logic [15:0] p_addr[2], p_wdata[2];
    logic [15:0] exp_d[2];
    logic [15:0] model_mem [256];
    logic [15:0] g_addr, g_wdata, g_rval;
    bit          e0, e1, w0, w1, r0, r1, en, d0, d1, busy;
    cyc = 0; acc_cyc = 0; acc_valid = 0; g = 0; g_wr = 0; last = 1;
    g_addr = '0; g_wdata = '0; g_rval = '0;
    pend = '{0, 0}; p_wr = '{0, 0}; p_addr = '{16'd0, 16'd0}; p_wdata = '{16'd0, 16'd0};
    exp_d = '{16'd0, 16'd0};
    model_mem = mem_a;
    for (int c = 0; c < n_cycles; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 99) < 2);
      for (int x = 0; x < 2; x++) begin
        if (!pend[x] && $urandom_range(0, 2) == 0) begin
          pend[x]    = 1'b1;
          p_wr[x]    = 1'($urandom_range(0, 1));
          p_addr[x]  = 16'($urandom_range(0, 31));
          p_wdata[x] = 16'($urandom);
        end
      end
      m0_exec = pend[0]; m0_write = p_wr[0]; m0_addr = p_addr[0]; m0_wdata = p_wdata[0];
      m1_exec = pend[1]; m1_write = p_wr[1]; m1_addr = p_addr[1]; m1_wdata = p_wdata[1];
      #1;
      e0   = pend[0];
      e1   = pend[1];
      busy = acc_valid && (cyc <= acc_cyc + 2 + LAT_A);
      w0   = RR ? (e0 && (!e1 || last)) : e0;
      w1   = e1 && !w0;
      r0   = !busy && !reset && w0;
      r1   = !busy && !reset && w1;
      en   = acc_valid && (cyc == acc_cyc + 1) && !reset;
      d0   = acc_valid && (cyc == acc_cyc + 2 + LAT_A) && !g && !reset;
      d1   = acc_valid && (cyc == acc_cyc + 2 + LAT_A) && g && !reset;
      checkOutput("rnd_m0_ready", {31'd0, a_m0_ready}, {31'd0, r0});
      checkOutput("rnd_m1_ready", {31'd0, a_m1_ready}, {31'd0, r1});
      checkOutput("rnd_m0_done", {31'd0, a_m0_done}, {31'd0, d0});
      checkOutput("rnd_m1_done", {31'd0, a_m1_done}, {31'd0, d1});
      checkOutput("rnd_ram_en", {31'd0, a_ram_en}, {31'd0, en});
      checkOutput("rnd_m0_data", {16'd0, a_m0_rdata}, {16'd0, exp_d[0]});
      checkOutput("rnd_m1_data", {16'd0, a_m1_rdata}, {16'd0, exp_d[1]});
      if (en) begin
        checkOutput("rnd_ram_addr", {16'd0, a_ram_addr}, {16'd0, g_addr});
        checkOutput("rnd_ram_write", {31'd0, a_ram_wr}, {31'd0, g_wr});
        if (g_wr) checkOutput("rnd_ram_wdata", {16'd0, a_ram_wdata}, {16'd0, g_wdata});
      end
      if (reset) begin
        acc_valid = 1'b0;
        exp_d     = '{16'd0, 16'd0};
        last      = 1'b1;
      end else begin
        if (acc_valid && cyc == acc_cyc + 1) begin
          if (g_wr) model_mem[g_addr[7:0]] = g_wdata;
          else      g_rval = model_mem[g_addr[7:0]];
        end
        if (acc_valid && cyc == acc_cyc + 1 + LAT_A && !g_wr) exp_d[g] = g_rval;
        if (r0 || r1) begin
          acc_valid = 1'b1;
          acc_cyc   = cyc;
          g         = r1;
          g_wr      = p_wr[r1];
          g_addr    = p_addr[r1];
          g_wdata   = p_wdata[r1];
          last      = r1;
          pend[r1]  = 1'b0;
        end
      end
      cyc++;
    end
    @(negedge clk);
    reset   = 1'b0;
    m0_exec = 1'b0;
    m1_exec = 1'b0;
  endtask

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed table, hand-written corner sequences, then random traffic.
  initial begin
    vec_t        vecs[6];
    logic [15:0] exp_cur[2];
    int          dk, dn, ng, both, m1_hits, dn_cnt, first_k;
    int          grants[4];
    int          gcyc[4];

    reset = 1'b1; preload = 1'b1;
    m0_exec = 1'b0; m0_write = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_exec = 1'b0; m1_write = 1'b0; m1_addr = '0; m1_wdata = '0;
    grants = '{0, 0, 0, 0};
    gcyc   = '{0, 0, 0, 0};

    @(negedge clk);
    preload = 1'b0;
    m0_exec = 1'b1;
    m1_exec = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_m0_ready", {31'd0, a_m0_ready}, 32'd0);
    checkOutput("rst_m1_ready", {31'd0, a_m1_ready}, 32'd0);
    checkOutput("rst_m0_done", {31'd0, a_m0_done}, 32'd0);
    checkOutput("rst_m1_done", {31'd0, a_m1_done}, 32'd0);
    checkOutput("rst_ram_en", {31'd0, a_ram_en}, 32'd0);
    checkOutput("rst_ram_wr", {31'd0, a_ram_wr}, 32'd0);
    checkOutput("rst_m0_data", {16'd0, a_m0_rdata}, 32'd0);
    checkOutput("rst_m1_data", {16'd0, a_m1_rdata}, 32'd0);
    checkOutput("rst_ram_addr", {16'd0, a_ram_addr}, 32'd0);
    checkOutput("rst_b_m0_ready", {31'd0, b_m0_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0; m0_exec = 1'b0; m1_exec = 1'b0;

    $display("[TB] table-driven transactions");
    vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vecs[1] = '{1'b1, 1'b1, 16'h0020, 16'h1234, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234};
    vecs[3] = '{1'b0, 1'b1, 16'h0030, 16'hA5A5, 16'hBEEF};
    vecs[4] = '{1'b0, 1'b0, 16'h0030, 16'h0000, 16'hA5A5};
    vecs[5] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    exp_cur = '{16'h0000, 16'h0000};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], dk, dn);
      checkOutput("tbl_done_latency", 32'(dk), 32'(LAT_A + 2));
      checkOutput("tbl_done_pulses", 32'(dn), 32'd1);
      exp_cur[vecs[i].who] = vecs[i].exp_rdata;
      checkOutput("tbl_data_own", {16'd0, vecs[i].who ? a_m1_rdata : a_m0_rdata},
                  {16'd0, exp_cur[vecs[i].who]});
      checkOutput("tbl_data_other", {16'd0, vecs[i].who ? a_m0_rdata : a_m1_rdata},
                  {16'd0, exp_cur[!vecs[i].who]});
    end

    $display("[TB] continuous tie");
    resetDut();
    m0_exec = 1'b1; m0_write = 1'b0; m0_addr = 16'h0010;
    m1_exec = 1'b1; m1_write = 1'b0; m1_addr = 16'h0020;
    ng = 0; both = 0; m1_hits = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #1;
      if (a_m0_ready && a_m1_ready) both++;
      if (a_m1_ready) m1_hits++;
      if (a_m0_ready || a_m1_ready) begin
        grants[ng] = int'(a_m1_ready);
        gcyc[ng]   = c;
        ng++;
      end
      @(negedge clk);
    end
    m0_exec = 1'b0; m1_exec = 1'b0;
    checkOutput("tie_accepts", 32'(ng), 32'd4);
    checkOutput("tie_both_ready", 32'(both), 32'd0);
    checkOutput("tie_m1_ready_count", 32'(m1_hits), RR ? 32'd2 : 32'd0);
    for (int j = 0; j < 4; j++) begin
      checkOutput("tie_grant", 32'(grants[j]), RR ? 32'(j % 2) : 32'd0);
      if (j > 0) checkOutput("tie_spacing", 32'(gcyc[j] - gcyc[j-1]), 32'(LAT_A + 3));
    end
    repeat (6) @(negedge clk);

    $display("[TB] m1 request while m0 busy");
    @(negedge clk);
    m0_exec = 1'b1; m0_write = 1'b0; m0_addr = 16'h0010;
    #1;
    checkOutput("busy_m0_accept", {31'd0, a_m0_ready}, 32'd1);
    @(negedge clk);
    m0_exec = 1'b0;
    @(negedge clk);
    m1_exec = 1'b1; m1_write = 1'b0; m1_addr = 16'h0020;
    #1;
    checkOutput("busy_m1_blocked_wait", {31'd0, a_m1_ready}, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("busy_m1_blocked_resp", {31'd0, a_m1_ready}, 32'd0);
    checkOutput("busy_m0_done", {31'd0, a_m0_done}, 32'd1);
    @(negedge clk);
    #1;
    checkOutput("busy_m1_first_idle", {31'd0, a_m1_ready}, 32'd1);
    @(negedge clk);
    m1_exec = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("busy_m0_data", {16'd0, a_m0_rdata}, 32'h0000BEEF);

    $display("[TB] reset during wait");
    @(negedge clk);
    m0_exec = 1'b1; m0_write = 1'b0; m0_addr = 16'h0010;
    #1;
    checkOutput("abort_accept", {31'd0, a_m0_ready}, 32'd1);
    @(negedge clk);
    m0_exec = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("abort_en_in_reset", {31'd0, a_ram_en}, 32'd0);
    checkOutput("abort_done_in_reset", {31'd0, a_m0_done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m1_exec = 1'b1; m1_write = 1'b0; m1_addr = 16'h0020;
    #1;
    checkOutput("abort_idle_after", {31'd0, a_m1_ready}, 32'd1);
    checkOutput("abort_ram_en_after", {31'd0, a_ram_en}, 32'd0);
    checkOutput("abort_m0_data", {16'd0, a_m0_rdata}, 32'd0);
    dn_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) m1_exec = 1'b0;
      #1;
      if (a_m0_done) dn_cnt++;
    end
    checkOutput("abort_no_done", 32'(dn_cnt), 32'd0);
    checkOutput("abort_m1_read", {16'd0, a_m1_rdata}, 32'h00001234);

    $display("[TB] latency 3 read");
    resetDut();
    m0_exec = 1'b1; m0_write = 1'b0; m0_addr = 16'h0040;
    #1;
    checkOutput("lat3_accept", {31'd0, b_m0_ready}, 32'd1);
    @(negedge clk);
    m0_exec = 1'b0;
    first_k = -1; dn_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      if (b_m0_done) begin
        dn_cnt++;
        if (first_k < 0) first_k = k;
      end
    end
    checkOutput("lat3_done_latency", 32'(first_k), 32'(LAT_B + 2));
    checkOutput("lat3_done_pulses", 32'(dn_cnt), 32'd1);
    checkOutput("lat3_data", {16'd0, b_m0_rdata}, 32'h0000CAFE);

    $display("[TB] random traffic");
    resetDut();
    runRandom(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
